// File: rtl/err_win_ctrl.sv
// Purpose : run sequencer for the PRBS error checker (clear, settle, windowed error deltas).
// Latency : snapshot is visible one cycle after its window-end edge; DONE one cycle after the last window.
// Backpres: one snapshot is held until it is acked; a window that ends while one is still held is dropped and sets OVF.
//
// Ports
//   CLK, RST_PER       checker clock, async active-high reset
//   start_i, abort_i   run request (accepted only in IDLE) / run terminate (wins over start)
//   win_len_i          window length in cycles (0 behaves as 1)
//   num_win_i          windows per run (0 = run until abort)
//   settle_len_i       cycles between clear release and the first window
//   err_cnt_i          free-running checker error count (wraps mod 2^32)
//   snap_ack_i         host consumed the held snapshot
//   cnt_clr_o          registered clear to the checker
//   snap_valid_o/_data_o/_idx_o   held window snapshot and its 0-based index
//   total_err_o        saturating run error sum
//   busy_o, done_o, ovf_o   not idle / run-complete pulse / sticky snapshot drop
module err_win_ctrl #(
    parameter int unsigned CLR_CYC = 2
) (
    input  logic        CLK,
    input  logic        RST_PER,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] win_len_i,
    input  logic [15:0] num_win_i,
    input  logic [7:0]  settle_len_i,
    input  logic [31:0] err_cnt_i,
    input  logic        snap_ack_i,
    output logic        cnt_clr_o,
    output logic        snap_valid_o,
    output logic [31:0] snap_data_o,
    output logic [15:0] snap_idx_o,
    output logic [31:0] total_err_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        ovf_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] tmr_q, tmr_d;             // shared down-counter: clear, settle, window
    logic [31:0] win_len_q, win_len_d;
    logic [15:0] num_win_q, num_win_d;
    logic [7:0]  settle_len_q, settle_len_d;
    logic [31:0] base_q, base_d;
    logic        base_vld_q, base_vld_d;   // low on the first RUN cycle, which captures the base
    logic [15:0] win_cnt_q, win_cnt_d;
    logic        cnt_clr_q, cnt_clr_d;
    logic        snap_valid_q, snap_valid_d;
    logic [31:0] snap_data_q, snap_data_d;
    logic [15:0] snap_idx_q, snap_idx_d;
    logic [31:0] total_q, total_d;
    logic        ovf_q, ovf_d;

    logic        win_end;
    logic [31:0] delta;
    logic [31:0] win_eff;
    logic [32:0] sum_w;

    assign delta   = err_cnt_i - base_q;   // modular subtraction absorbs counter wrap
    assign win_eff = (win_len_q == 32'd0) ? 32'd1 : win_len_q;
    assign sum_w   = {1'b0, total_q} + {1'b0, delta};

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        win_len_d    = win_len_q;
        num_win_d    = num_win_q;
        settle_len_d = settle_len_q;
        base_d       = base_q;
        base_vld_d   = base_vld_q;
        win_cnt_d    = win_cnt_q;
        snap_valid_d = snap_valid_q;
        snap_data_d  = snap_data_q;
        snap_idx_d   = snap_idx_q;
        total_d      = total_q;
        ovf_d        = ovf_q;
        win_end      = 1'b0;

        if ((state_q != S_IDLE) && abort_i) begin
            // Partial window is discarded: no snapshot, no total update.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        state_d      = S_CLEAR;
                        tmr_d        = 32'(CLR_CYC);
                        win_len_d    = win_len_i;
                        num_win_d    = num_win_i;
                        settle_len_d = settle_len_i;
                        base_vld_d   = 1'b0;
                        win_cnt_d    = 16'd0;
                        snap_idx_d   = 16'd0;
                        total_d      = 32'd0;
                        ovf_d        = 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (tmr_q == 32'd1) begin
                        if (settle_len_q == 8'd0) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_SETTLE;
                            tmr_d   = {24'd0, settle_len_q};
                        end
                    end else begin
                        tmr_d = tmr_q - 32'd1;
                    end
                end
                S_SETTLE: begin
                    if (tmr_q == 32'd1) begin
                        state_d = S_RUN;
                    end else begin
                        tmr_d = tmr_q - 32'd1;
                    end
                end
                S_RUN: begin
                    if (!base_vld_q) begin
                        base_d     = err_cnt_i;
                        base_vld_d = 1'b1;
                        tmr_d      = win_eff;
                    end else if (tmr_q == 32'd1) begin
                        win_end   = 1'b1;
                        base_d    = err_cnt_i;   // next window starts on this same edge
                        tmr_d     = win_eff;
                        total_d   = sum_w[32] ? 32'hFFFF_FFFF : sum_w[31:0];
                        win_cnt_d = win_cnt_q + 16'd1;
                        if ((num_win_q != 16'd0) && (win_cnt_q + 16'd1 == num_win_q)) begin
                            state_d = S_FINISH;
                        end
                    end else begin
                        tmr_d = tmr_q - 32'd1;
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Handshake runs in every state, so a pending snapshot survives abort and idle.
        if (snap_valid_q && snap_ack_i) begin
            snap_valid_d = 1'b0;
        end
        if (win_end) begin
            if (!snap_valid_q || snap_ack_i) begin
                snap_valid_d = 1'b1;
                snap_data_d  = delta;
                snap_idx_d   = win_cnt_q;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign cnt_clr_d = (state_d == S_CLEAR);

    always_ff @(posedge CLK or posedge RST_PER) begin
        if (RST_PER) begin
            state_q      <= S_IDLE;
            tmr_q        <= 32'd0;
            win_len_q    <= 32'd0;
            num_win_q    <= 16'd0;
            settle_len_q <= 8'd0;
            base_q       <= 32'd0;
            base_vld_q   <= 1'b0;
            win_cnt_q    <= 16'd0;
            cnt_clr_q    <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_data_q  <= 32'd0;
            snap_idx_q   <= 16'd0;
            total_q      <= 32'd0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            win_len_q    <= win_len_d;
            num_win_q    <= num_win_d;
            settle_len_q <= settle_len_d;
            base_q       <= base_d;
            base_vld_q   <= base_vld_d;
            win_cnt_q    <= win_cnt_d;
            cnt_clr_q    <= cnt_clr_d;
            snap_valid_q <= snap_valid_d;
            snap_data_q  <= snap_data_d;
            snap_idx_q   <= snap_idx_d;
            total_q      <= total_d;
            ovf_q        <= ovf_d;
        end
    end

    assign cnt_clr_o    = cnt_clr_q;
    assign snap_valid_o = snap_valid_q;
    assign snap_data_o  = snap_data_q;
    assign snap_idx_o   = snap_idx_q;
    assign total_err_o  = total_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_FINISH);
    assign ovf_o        = ovf_q;

endmodule
